// File: rtl/nand3_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : nand3_vector_checker
// Brief    : Sweeps all eight a/b/c vectors into a 3-input NAND under test and
//            counts mismatches. Define NAND3_CHK_FAILCAP_EN for first-fail capture.
// Revision : 1.0 - initial release
// ============================================================================
module nand3_vector_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_idx,
  output logic             fail_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]       c_hold_last = 8'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] c_err_max   = '1;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_vec, w_vec_nxt;
  logic [7:0]       r_hold, w_hold_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             w_sample;
  logic             w_mismatch;

  // Abort outranks the sampling edge, so a coinciding comparison is dropped.
  assign w_sample   = (r_state == DRIVE) && (r_hold == c_hold_last) && !abort;
  assign w_mismatch = w_sample && (dut_out != (~&r_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= 3'd0;
      r_hold  <= 8'd0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_hold_nxt  = r_hold;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = DRIVE;
          w_vec_nxt   = 3'd0;
          w_hold_nxt  = 8'd0;
          w_err_nxt   = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_vec_nxt   = 3'd0;
          w_hold_nxt  = 8'd0;
        end else if (w_sample) begin
          if (w_mismatch && (r_err != c_err_max)) begin
            w_err_nxt = r_err + 1'b1;
          end
          if (r_vec == 3'd7) begin
            w_state_nxt = DONE;
          end else begin
            w_vec_nxt  = r_vec + 3'd1;
            w_hold_nxt = 8'd0;
          end
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = 3'd0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  // The vector register itself is the stimulus; DONE keeps it at 7.
  assign a       = r_vec[2];
  assign b       = r_vec[1];
  assign c       = r_vec[0];
  assign busy    = (r_state == DRIVE);
  assign done    = (r_state == DONE);
  assign pass    = done && (r_err == '0);
  assign err_cnt = r_err;

`ifdef NAND3_CHK_FAILCAP_EN
  logic       w_restart;
  logic [2:0] r_fail_idx;
  logic       r_fail_valid;

  assign w_restart = start && (r_state != DRIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_idx   <= 3'd0;
      r_fail_valid <= 1'b0;
    end else if (w_restart) begin
      r_fail_idx   <= 3'd0;
      r_fail_valid <= 1'b0;
    end else if (w_mismatch && !r_fail_valid) begin
      r_fail_idx   <= r_vec;
      r_fail_valid <= 1'b1;
    end
  end

  assign fail_idx   = r_fail_idx;
  assign fail_valid = r_fail_valid;
`else
  assign fail_idx   = 3'd0;
  assign fail_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nand3_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand3_vector_checker
// Brief    : Scoreboard bench; fault masks on the modelled NAND, sweep results
//            predicted from mismatch counts. Honours NAND3_CHK_FAILCAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand3_vector_checker;

  localparam int HOLD = 4;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dut_out;
  logic          a, b, c, busy, done, pass, fail_valid;
  logic [EW-1:0] err_cnt;
  logic [2:0]    fail_idx;
  logic [7:0]    fault_mask = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int start_cyc;
    int err;
    int pass;
    int fidx;
    int fvalid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic done_q = 1'b0;

  nand3_vector_checker #(.HOLD_CYCLES(HOLD), .ERR_W(EW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NAND under test: a set mask bit inverts the answer for that vector.
  always_comb dut_out = ~(a & b & c) ^ fault_mask[{a, b, c}];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [7:0] mask, input int sc);
    exp_t e;
    int   errs = 0;
    e.fidx   = 0;
    e.fvalid = 0;
    for (int v = 0; v < 8; v++) begin
      if (mask[v]) begin
        errs++;
        if (e.fvalid == 0) begin
          e.fidx   = v;
          e.fvalid = 1;
        end
      end
    end
    e.err  = (errs > EMAX) ? EMAX : errs;
    e.pass = (errs == 0) ? 1 : 0;
`ifndef NAND3_CHK_FAILCAP_EN
    e.fidx   = 0;
    e.fvalid = 0;
`endif
    e.start_cyc = sc;
    return e;
  endfunction

  // Monitor: every rising done is matched against the oldest predicted sweep.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_latency", cyc - mon_e.start_cyc, 8 * HOLD);
        check("done_err_cnt", int'(err_cnt), mon_e.err);
        check("done_pass", int'(pass), mon_e.pass);
        check("done_fail_idx", int'(fail_idx), mon_e.fidx);
        check("done_fail_valid", int'(fail_valid), mon_e.fvalid);
        check("done_abc", int'({a, b, c}), 7);
        check("done_busy", int'(busy), 0);
      end
    end
    done_q = done;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_sweep(input logic [7:0] mask, input bit expect_done);
    fault_mask = mask;
    pulse_start();
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    check("start_pass", int'(pass), 0);
    check("start_err_clr", int'(err_cnt), 0);
    check("start_fv_clr", int'(fail_valid), 0);
    check("start_abc", int'({a, b, c}), 0);
    if (expect_done) sb.push_back(model(mask, cyc));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_abc"}, int'({a, b, c}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_cnt), 0);
    check({tag, "_fidx"}, int'(fail_idx), 0);
    check({tag, "_fvalid"}, int'(fail_valid), 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("no_autostart", int'(busy), 0);

    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_done", int'(done), 0);

    begin_sweep(8'h00, 1'b1); wait_done();   // correct NAND
    begin_sweep(8'h80, 1'b1); wait_done();   // stuck-at-1, restart from DONE
    begin_sweep(8'h7F, 1'b1); wait_done();   // stuck-at-0, saturation

    // Abort during vector 3, errors already seen on vectors 0 and 2.
    begin_sweep(8'h05, 1'b0);
    repeat (13) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_abc", int'({a, b, c}), 0);
    check("abort_err_kept", int'(err_cnt), 2);
`ifdef NAND3_CHK_FAILCAP_EN
    check("abort_fv_kept", int'(fail_valid), 1);
`endif
    begin_sweep(8'h00, 1'b1); wait_done();

    // Abort on the final sampling edge: vector 7 comparison must be lost.
    begin_sweep(8'h80, 1'b0);
    repeat (31) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("lastabort_busy", int'(busy), 0);
    check("lastabort_done", int'(done), 0);
    check("lastabort_err", int'(err_cnt), 0);
    check("lastabort_abc", int'({a, b, c}), 0);
    repeat (4) @(posedge clk);
    #1 check("lastabort_stays_idle", int'(done), 0);

    // Start re-pulsed during vector 5 is ignored.
    begin_sweep(8'h21, 1'b1);
    repeat (20) @(posedge clk);
    pulse_start();
    check("restart_ignored_busy", int'(busy), 1);
    check("restart_ignored_abc", int'({a, b, c}), 5);
    wait_done();

    // Reset during vector 2.
    begin_sweep(8'h01, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("midrst_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      begin_sweep(8'($urandom_range(0, 255)), 1'b1);
      wait_done();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
